// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad: key-code constants, the
// index-to-one-hot mapping used by both the scanner and the emulator, and
// the emulator state encoding.
//
// Key code layout: [3:2] column index, [1:0] row index.
//   row0: 1 2 3 +   row1: 4 5 6 -   row2: 7 8 9 *   row3: - 0 - =
package keypad_pkg;

  localparam logic [3:0] KEY_1   = 4'b0000;
  localparam logic [3:0] KEY_2   = 4'b0100;
  localparam logic [3:0] KEY_3   = 4'b1000;
  localparam logic [3:0] KEY_ADD = 4'b1100;
  localparam logic [3:0] KEY_4   = 4'b0001;
  localparam logic [3:0] KEY_5   = 4'b0101;
  localparam logic [3:0] KEY_6   = 4'b1001;
  localparam logic [3:0] KEY_SUB = 4'b1101;
  localparam logic [3:0] KEY_7   = 4'b0010;
  localparam logic [3:0] KEY_8   = 4'b0110;
  localparam logic [3:0] KEY_9   = 4'b1010;
  localparam logic [3:0] KEY_MUL = 4'b1110;
  localparam logic [3:0] KEY_0   = 4'b0111;
  localparam logic [3:0] KEY_EQ  = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StGap
  } emu_state_e;

  // Index 0 is the most significant line: 00->1000 ... 11->0001.
  function automatic logic [3:0] col_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  function automatic logic [3:0] row_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

endpackage

// File: rtl/keypad_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that supplies pseudo-random contact
// bounce for the keypad emulator. Advances every cycle; reloads the seed on
// reset.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   o_bit  current LFSR bit 0 (contact state during a bounce window)
module keypad_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  output logic o_bit
);

  logic [7:0] r_lfsr;
  logic       w_feedback;

  // Taps 8,6,5,4 in 1-based numbering map to bits 7,5,4,3.
  assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_feedback};
    end
  end

  assign o_bit = r_lfsr[0];

endmodule

// File: rtl/keypad_emulator.sv
// Keypad-side model of a 4x4 matrix keypad. Accepts one key code per
// valid/ready handshake, holds the key down for PRESS_CYCLES (answering the
// scanner's column strobe combinationally on rows), releases all keys for
// GAP_CYCLES, then pulses press_done on the first idle cycle.
//
// Build option: define KEYPAD_EMU_BOUNCE_EN to add LFSR-driven contact bounce
// during the first BOUNCE_CYCLES cycles of each press and each gap.
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   key_valid   key request present
//   key_code    [3:2] column index, [1:0] row index
//   key_ready   emulator can accept a request
//   cols        one-hot column strobe from the scanner
//   rows        one-hot row drive back to the scanner
//   busy        press or gap in progress
//   press_done  one-cycle pulse when a press/gap sequence completes
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned PRESS_CYCLES  = 20,
  parameter int unsigned GAP_CYCLES    = 20,
`ifdef KEYPAD_EMU_BOUNCE_EN
  parameter int unsigned BOUNCE_CYCLES = 4,
`endif
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       busy,
  output logic       press_done
);

  emu_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [3:0]       r_code, w_code_next;
  logic             r_press_done, w_press_done_next;
  logic             w_col_match;
  logic             w_contact;

  assign key_ready  = (r_state == StIdle) && !rst;
  assign busy       = (r_state != StIdle);
  assign press_done = r_press_done;

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_code_next       = r_code;
    w_press_done_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (key_valid && key_ready) begin
          w_code_next  = key_code;
          w_cnt_next   = CNT_W'(PRESS_CYCLES - 1);
          w_state_next = StPress;
        end
      end
      StPress: begin
        if (r_cnt == '0) begin
          w_cnt_next   = CNT_W'(GAP_CYCLES - 1);
          w_state_next = StGap;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      StGap: begin
        if (r_cnt == '0) begin
          w_state_next      = StIdle;
          w_press_done_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_code       <= '0;
      r_press_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_code       <= w_code_next;
      r_press_done <= w_press_done_next;
    end
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic w_lfsr_bit;
  logic w_in_window;

  keypad_lfsr8 #(
    .SEED (8'hA5)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .o_bit (w_lfsr_bit)
  );

  // The counter counts down from N-1, so the first B cycles of a phase are
  // those with r_cnt >= N-B.
  assign w_in_window =
      ((r_state == StPress) && (r_cnt >= CNT_W'(PRESS_CYCLES - BOUNCE_CYCLES))) ||
      ((r_state == StGap)   && (r_cnt >= CNT_W'(GAP_CYCLES - BOUNCE_CYCLES)));

  assign w_contact = w_in_window ? w_lfsr_bit : (r_state == StPress);
`else
  assign w_contact = (r_state == StPress);
`endif

  // Exact compare also rejects an all-zero or multi-hot strobe.
  assign w_col_match = (cols == col_onehot(r_code[3:2]));

  assign rows = (!rst && w_contact && w_col_match) ? row_onehot(r_code[1:0]) : 4'b0000;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  localparam int P = 20;
  localparam int G = 20;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'b0000;
  logic       key_ready;
  logic [3:0] cols = 4'b0000;
  logic [3:0] rows;
  logic       busy;
  logic       press_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycle of the accepted handshake and its code.
  int         cyc = 0;
  int         hs_cyc = -1;
  logic [3:0] hs_code = 4'b0000;

  logic [3:0] obs_rows;
  logic       obs_pd;

  int         lat;
  logic [3:0] dec;
  logic       seen;

  keypad_emulator u_dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .cols       (cols),
    .rows       (rows),
    .busy       (busy),
    .press_done (press_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] onehot(input int idx);
    return 4'(1 << (3 - idx));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the
  // model, then advance the model across the next rising edge.
  task automatic step(input logic t_rst, input logic t_valid, input logic [3:0] t_code,
                      input logic [3:0] t_cols);
    int         k;
    bit         act, in_press, exp_busy, exp_pd, exp_ready, skip_rows;
    logic [3:0] exp_rows;
    @(negedge clk);
    rst       = t_rst;
    key_valid = t_valid;
    key_code  = t_code;
    cols      = t_cols;
    #1;
    act       = (hs_cyc >= 0);
    k         = cyc - hs_cyc;
    in_press  = act && k >= 1 && k <= P;
    exp_busy  = act && k >= 1 && k <= P + G;
    exp_pd    = act && k == P + G + 1;
    exp_ready = !t_rst && !exp_busy;
    exp_rows  = (!t_rst && in_press && t_cols == onehot(int'(hs_code[3:2]))) ?
                onehot(int'(hs_code[1:0])) : 4'b0000;
    skip_rows = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
    skip_rows = !t_rst && act && ((k >= 1 && k <= B) || (k >= P + 1 && k <= P + B));
`endif
    if (!skip_rows) check_eq("rows", {28'd0, rows}, {28'd0, exp_rows});
    check_eq("key_ready", {31'd0, key_ready}, {31'd0, exp_ready});
    check_eq("busy", {31'd0, busy}, {31'd0, exp_busy});
    check_eq("press_done", {31'd0, press_done}, {31'd0, exp_pd});
    obs_rows = rows;
    obs_pd   = press_done;
    if (t_rst) begin
      hs_cyc = -1;
    end else if (t_valid && exp_ready) begin
      hs_cyc  = cyc;
      hs_code = t_code;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom), onehot(i % 4));
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // Reset state; a request under reset is not taken.
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 4'b0101, 4'b0100);

    // Clean press of KEY_5 and completion latency.
    step(1'b0, 1'b1, 4'b0101, 4'b0100);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b0, 1'b0, 4'($urandom), onehot(i % 4));
      if (obs_pd) begin
        lat = i;
        break;
      end
    end
    check_eq("t1_done_latency", lat, 41);

    // Back-to-back: KEY_1 then KEY_EQ with valid held high.
    step(1'b0, 1'b1, 4'b0000, 4'b1000);
    for (int i = 0; i < 45; i++) step(1'b0, 1'b1, 4'b1111, onehot(i % 4));
    idle_steps(40);

    // Request while busy is ignored.
    step(1'b0, 1'b1, 4'b0110, 4'b0100);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 4'b1001, (i % 2 == 0) ? 4'b0100 : 4'b0010);
    idle_steps(35);

    // Reset at press cycle 7.
    step(1'b0, 1'b1, 4'b0110, 4'b0100);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'b0000, 4'b0100);
    step(1'b1, 1'b0, 4'b0000, 4'b0100);
    step(1'b1, 1'b0, 4'b0000, 4'b0100);
    idle_steps(45);

    // Bad column strobes.
    step(1'b0, 1'b1, 4'b0101, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: step(1'b0, 1'b0, 4'b0000, 4'b0000);
        1: step(1'b0, 1'b0, 4'b0000, 4'b0011);
        2: step(1'b0, 1'b0, 4'b0000, 4'b1111);
        default: step(1'b0, 1'b0, 4'b0000, 4'b0100);
      endcase
    end
    idle_steps(30);

    // Loopback-style scan of KEY_7.
    step(1'b0, 1'b1, 4'b0010, 4'b1000);
    dec  = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < P; i++) begin
      step(1'b0, 1'b0, 4'b0000, onehot(i % 4));
      if (obs_rows != 4'b0000) begin
        seen = 1'b1;
        for (int j = 0; j < 4; j++) begin
          if (obs_rows == onehot(j)) dec = {2'(i % 4), 2'(j)};
        end
      end
    end
    check_eq("t6_seen", {31'd0, seen}, 32'd1);
    check_eq("t6_decode", {28'd0, dec}, 32'h2);
    idle_steps(25);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic       r_r, r_v;
      logic [3:0] r_c, r_k;
      r_r = ($urandom_range(0, 199) == 0);
      r_v = ($urandom_range(0, 2) == 0);
      r_k = 4'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: r_c = onehot(int'(hs_code[3:2]));
        5, 6, 7:       r_c = onehot(int'($urandom_range(0, 3)));
        default:       r_c = 4'($urandom);
      endcase
      step(r_r, r_v, r_k, r_c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
